// File: rtl/timestamp_capture_master_pkg.sv
// Shared definitions for the timestamp capture master: timer register map,
// sequencer states and the queue entry width.
package timestamp_capture_master_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  // Queue entry layout: {irq_src, snap_h, snap_l}
  localparam int ENTRY_W = 33;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_RDL,
    ST_RDH,
    ST_HCAP,
    ST_CLR,
    ST_PUSH
  } state_t;

endpackage

// File: rtl/timestamp_capture_master_ts_fifo.sv
// Synchronous show-ahead FIFO; the head output holds the last popped entry
// while the queue is empty.
module ts_fifo
  import timestamp_capture_master_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] last_q;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a push against a full queue is
  // still accepted when it coincides with a pop.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? last_q : mem[rd_ptr];

  // NOTE: storage has no reset; every slot is written before it can be read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/timestamp_capture_master.sv
// Avalon-MM master that snapshots the interval timer on a software request or
// an irq rising edge and queues the 32-bit timestamp tagged with its source.
module timestamp_capture_master
  import timestamp_capture_master_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter bit CLEAR_ON_IRQ = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        capture_req,
  input  logic        irq_in,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  output logic        ts_valid,
  output logic [31:0] ts_data,
  output logic        ts_irq_src,
  input  logic        ts_ready,
  output logic        busy,
  output logic [7:0]  drop_count
);

  state_t             state;
  logic               irq_prev;
  logic               irq_pend;
  logic               cap_pend;
  logic               src;
  logic [15:0]        snap_l;
  logic [15:0]        snap_h;
  logic               irq_rise, irq_trig, cap_trig;
  logic               svc_irq, svc_cap;
  logic               irq_drop, cap_drop, fifo_drop;
  logic               push, pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] head;
  logic [1:0]         drop_inc;
  logic [8:0]         drop_sum;

  assign irq_rise = irq_in & ~irq_prev;
  assign irq_trig = irq_pend | irq_rise;
  assign cap_trig = cap_pend | capture_req;
  // irq wins arbitration; a capture seen alongside it stays pending.
  assign svc_irq  = (state == ST_IDLE) & irq_trig;
  assign svc_cap  = (state == ST_IDLE) & ~irq_trig & cap_trig;
  assign irq_drop = irq_rise & irq_pend & ~svc_irq;
  assign cap_drop = capture_req & cap_pend & ~svc_cap;

  assign push      = (state == ST_PUSH);
  assign pop       = ts_valid & ts_ready;
  assign fifo_drop = push & fifo_full & ~pop;
  assign drop_inc  = {1'b0, irq_drop} + {1'b0, cap_drop} + {1'b0, fifo_drop};
  assign drop_sum  = {1'b0, drop_count} + {7'd0, drop_inc};

  assign ts_valid   = ~fifo_empty;
  assign ts_irq_src = head[ENTRY_W-1];
  assign ts_data    = head[31:0];
  assign busy       = (state != ST_IDLE);

  // NOTE: the bus outputs are registered alongside the state they belong to,
  // so each transition assigns the outputs of the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      irq_prev       <= 1'b0;
      irq_pend       <= 1'b0;
      cap_pend       <= 1'b0;
      src            <= 1'b0;
      snap_l         <= '0;
      snap_h         <= '0;
      drop_count     <= '0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= ADDR_STATUS;
      tmr_writedata  <= '0;
    end else begin
      irq_prev   <= irq_in;
      irq_pend   <= svc_irq ? (irq_pend & irq_rise)    : (irq_pend | irq_rise);
      cap_pend   <= svc_cap ? (cap_pend & capture_req) : (cap_pend | capture_req);
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= ADDR_STATUS;
      tmr_writedata  <= '0;

      case (state)
        ST_IDLE: begin
          if (svc_irq || svc_cap) begin
            state          <= ST_SNAP;
            src            <= svc_irq;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= ADDR_SNAPL;
          end
        end
        ST_SNAP: begin
          state          <= ST_RDL;
          tmr_chipselect <= 1'b1;
          tmr_address    <= ADDR_SNAPL;
        end
        ST_RDL: begin
          state          <= ST_RDH;
          tmr_chipselect <= 1'b1;
          tmr_address    <= ADDR_SNAPH;
        end
        ST_RDH: begin
          state  <= ST_HCAP;
          snap_l <= tmr_readdata;
        end
        ST_HCAP: begin
          snap_h <= tmr_readdata;
          if (src && CLEAR_ON_IRQ) begin
            state          <= ST_CLR;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= ADDR_STATUS;
          end else begin
            state <= ST_PUSH;
          end
        end
        ST_CLR:  state <= ST_PUSH;
        ST_PUSH: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  ts_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (push),
    .push_data ({src, snap_h, snap_l}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_timestamp_capture_master.sv
// Directed bench for timestamp_capture_master with a small interval-timer
// slave model answering snapshot writes and snap_l/snap_h reads.
module tb_timestamp_capture_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        capture_req = 1'b0;
  logic        irq_in = 1'b0;
  logic        ts_ready = 1'b0;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        ts_valid;
  logic [31:0] ts_data;
  logic        ts_irq_src;
  logic        busy;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] snap_val = '0;
  logic [31:0] snap_q = '0;

  int wr4_cyc = -1, rd4_cyc = -1, rd5_cyc = -1, wr0_cyc = -1, vrise_cyc = -1;
  int wr0_cnt = 0;
  logic prev_valid = 1'b0;

  timestamp_capture_master #(
    .FIFO_DEPTH   (4),
    .CLEAR_ON_IRQ (1'b1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .capture_req    (capture_req),
    .irq_in         (irq_in),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_readdata   (tmr_readdata),
    .ts_valid       (ts_valid),
    .ts_data        (ts_data),
    .ts_irq_src     (ts_irq_src),
    .ts_ready       (ts_ready),
    .busy           (busy),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Timer slave: snapshot latched on a write to SNAPL, registered readdata.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_readdata <= '0;
    end else if (tmr_chipselect && tmr_write_n) begin
      if (tmr_address == 3'd4)      tmr_readdata <= snap_q[15:0];
      else if (tmr_address == 3'd5) tmr_readdata <= snap_q[31:16];
      else                          tmr_readdata <= 16'h0000;
    end
  end

  always @(posedge clk) begin
    if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd4) snap_q <= snap_val;
  end

  // Bus / queue event log, sampled mid-cycle.
  always @(negedge clk) begin
    if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd4) wr4_cyc = cyc;
    if (tmr_chipselect &&  tmr_write_n && tmr_address == 3'd4) rd4_cyc = cyc;
    if (tmr_chipselect &&  tmr_write_n && tmr_address == 3'd5) rd5_cyc = cyc;
    if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) begin
      wr0_cyc = cyc;
      wr0_cnt = wr0_cnt + 1;
    end
    if (ts_valid && !prev_valid) vrise_cyc = cyc;
    prev_valid = ts_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_cap();
    capture_req = 1'b1;
    step(1);
    capture_req = 1'b0;
  endtask

  task automatic pop_one();
    ts_ready = 1'b1;
    step(1);
    ts_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      step(1);
      n++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;
    logic [31:0] exp_tail [4];
    exp_tail[0] = 32'd2;
    exp_tail[1] = 32'd3;
    exp_tail[2] = 32'd4;
    exp_tail[3] = 32'd7;

    // Reset values
    step(2);
    check("rst_cs",    {31'b0, tmr_chipselect}, 32'd0);
    check("rst_wn",    {31'b0, tmr_write_n},    32'd1);
    check("rst_addr",  {29'b0, tmr_address},    32'd0);
    check("rst_wdata", {16'b0, tmr_writedata},  32'd0);
    check("rst_valid", {31'b0, ts_valid},       32'd0);
    check("rst_data",  ts_data,                 32'd0);
    check("rst_src",   {31'b0, ts_irq_src},     32'd0);
    check("rst_busy",  {31'b0, busy},           32'd0);
    check("rst_drop",  {24'b0, drop_count},     32'd0);
    reset_n = 1'b1;
    step(2);

    // Software capture: bus sequence and latency
    snap_val = 32'h0001_2345;
    n = cyc;
    pulse_cap();
    step(8);
    check("cap_wr4",   wr4_cyc,   n + 1);
    check("cap_rd4",   rd4_cyc,   n + 2);
    check("cap_rd5",   rd5_cyc,   n + 3);
    check("cap_valid", vrise_cyc, n + 6);
    check("cap_data",  ts_data,   32'h0001_2345);
    check("cap_src",   {31'b0, ts_irq_src}, 32'd0);
    check("cap_noclr", wr0_cnt,   32'd0);
    pop_one();
    check("cap_empty", {31'b0, ts_valid}, 32'd0);

    // irq capture with status clear
    snap_val = 32'h0000_FBCF;
    w0 = wr0_cnt;
    n = cyc;
    irq_in = 1'b1;
    step(10);
    check("irq_wr0",   wr0_cyc,   n + 5);
    check("irq_wr0n",  wr0_cnt,   w0 + 1);
    check("irq_valid", vrise_cyc, n + 7);
    check("irq_data",  ts_data,   32'h0000_FBCF);
    check("irq_src",   {31'b0, ts_irq_src}, 32'd1);
    irq_in = 1'b0;
    step(10);
    check("irq_idle",  {31'b0, busy}, 32'd0);
    pop_one();
    check("irq_single", {31'b0, ts_valid}, 32'd0);
    check("irq_hold",   ts_data, 32'h0000_FBCF);

    // Simultaneous irq rise and capture_req
    snap_val = 32'h3333_0003;
    irq_in = 1'b1;
    capture_req = 1'b1;
    step(1);
    capture_req = 1'b0;
    step(20);
    check("both_drop",  {24'b0, drop_count}, 32'd0);
    check("both_v1",    {31'b0, ts_valid},   32'd1);
    check("both_src1",  {31'b0, ts_irq_src}, 32'd1);
    pop_one();
    check("both_v2",    {31'b0, ts_valid},   32'd1);
    check("both_src2",  {31'b0, ts_irq_src}, 32'd0);
    check("both_data2", ts_data, 32'h3333_0003);
    pop_one();
    check("both_empty", {31'b0, ts_valid},   32'd0);
    irq_in = 1'b0;
    step(2);

    // Overflow: six captures into a depth-4 queue with no consumer
    for (int i = 1; i <= 6; i++) begin
      snap_val = i;
      pulse_cap();
      wait_idle("ovf_idle");
    end
    check("ovf_drop", {24'b0, drop_count}, 32'd2);
    check("ovf_head", ts_data, 32'd1);
    // Push coincides with a pop while full: push accepted
    snap_val = 32'd7;
    pulse_cap();
    step(4);
    ts_ready = 1'b1;
    step(1);
    ts_ready = 1'b0;
    wait_idle("pp_idle");
    check("pp_drop", {24'b0, drop_count}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      check("pp_valid", {31'b0, ts_valid}, 32'd1);
      check("pp_data",  ts_data, exp_tail[i]);
      pop_one();
    end
    check("pp_empty", {31'b0, ts_valid}, 32'd0);

    // Three pulses while a sequence is in flight
    snap_val = 32'h0005_0001;
    pulse_cap();
    step(1);
    pulse_cap();
    pulse_cap();
    snap_val = 32'h0005_0002;
    step(20);
    check("tri_drop",  {24'b0, drop_count}, 32'd3);
    check("tri_d1",    ts_data, 32'h0005_0001);
    pop_one();
    check("tri_v2",    {31'b0, ts_valid}, 32'd1);
    check("tri_d2",    ts_data, 32'h0005_0002);
    pop_one();
    check("tri_empty", {31'b0, ts_valid}, 32'd0);

    // Reset during RDH
    snap_val = 32'h0006_0006;
    pulse_cap();
    step(2);
    check("mid_rdh_addr", {29'b0, tmr_address}, 32'd5);
    reset_n = 1'b0;
    #1;
    check("mid_cs",    {31'b0, tmr_chipselect}, 32'd0);
    check("mid_wn",    {31'b0, tmr_write_n},    32'd1);
    check("mid_addr",  {29'b0, tmr_address},    32'd0);
    check("mid_busy",  {31'b0, busy},           32'd0);
    check("mid_valid", {31'b0, ts_valid},       32'd0);
    check("mid_drop",  {24'b0, drop_count},     32'd0);
    check("mid_data",  ts_data,                 32'd0);
    step(2);
    reset_n = 1'b1;
    step(2);
    check("post_empty", {31'b0, ts_valid}, 32'd0);
    snap_val = 32'h0006_0007;
    n = cyc;
    pulse_cap();
    step(8);
    check("post_wr4",   wr4_cyc,   n + 1);
    check("post_rd5",   rd5_cyc,   n + 3);
    check("post_valid", vrise_cyc, n + 6);
    check("post_data",  ts_data,   32'h0006_0007);
    check("post_src",   {31'b0, ts_irq_src}, 32'd0);
    pop_one();
    check("post_pop",   {31'b0, ts_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
